coin_change_dispenser: RTL and testbench

Parametrised multi-denomination coin store with a change-making engine. Holds a count per denomination, loaded in bulk. Accepts change requests over a valid/ready handshake and dispenses greedily, one coin per handshake, on a valid/ready coin interface to the mechanism driver. Reports the completion status and any shortfall. Sits between the vending controller (requests) and the coin-ejector actuator logic.

---
 rtl/coin_pkg.sv | 33 +++
 rtl/coin_select_prio.sv | 24 ++
 rtl/coin_change_dispenser.sv | 126 ++++++++++++
 tb/tb_coin_change_dispenser.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin change dispenser.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam int DEF_NUM_DENOM = 4;
  localparam int DEF_AMT_W     = 12;

  // Index 0 sits in the LSBs and is the largest coin: 25, 10, 5, 1 cents.
  localparam logic [DEF_NUM_DENOM*DEF_AMT_W-1:0] DEF_DENOM_VALUES =
    {12'd1, 12'd5, 12'd10, 12'd25};

  // Widest packed denomination vector the helper accepts.
  localparam int VEC_MAX = 1024;

  // Extracts field idx (w bits wide) from a packed denomination vector.
  // Values wider than 32 bits are not supported.
  function automatic logic [31:0] denom_field(input logic [VEC_MAX-1:0] values,
                                              input int idx, input int w);
    logic [VEC_MAX-1:0] shifted;
    logic [31:0]        mask;
    shifted = values >> (idx * w);
    mask    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/coin_select_prio.sv
// Lowest-index priority encoder over the per-denomination eligibility flags.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies sel with any_eligible.
// Ports: eligible (one flag per denomination) -> any_eligible, sel.
module coin_select_prio #(
  parameter int NUM_DENOM = 4,
  parameter int IDX_W     = (NUM_DENOM > 1) ? $clog2(NUM_DENOM) : 1
) (
  input  logic [NUM_DENOM-1:0] eligible,
  output logic                 any_eligible,
  output logic [IDX_W-1:0]     sel
);

  assign any_eligible = |eligible;

  // Scan from the top so the lowest eligible index (largest coin) wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IDX_W'(i);
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Coin store with greedy change engine: per-denomination counters, one coin per handshake.
// Latency: first coin the cycle after request accept; done pulse the cycle after the last coin.
// Backpressure: coin_ready low holds coin_valid/coin_idx stable; req_ready only in IDLE without load.
// Ports: clk/reset; load/load_counts bulk load; req_valid/req_ready/req_amount request;
//        coin_valid/coin_ready/coin_idx ejector; done_valid/done_short/done_remain status;
//        counts/empty/all_empty store status.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int NUM_DENOM = DEF_NUM_DENOM,
  parameter int CNT_W     = 8,
  parameter int AMT_W     = DEF_AMT_W,
  parameter logic [NUM_DENOM*AMT_W-1:0] DENOM_VALUES = DEF_DENOM_VALUES,
  parameter int IDX_W     = (NUM_DENOM > 1) ? $clog2(NUM_DENOM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [NUM_DENOM*CNT_W-1:0] load_counts,
  input  logic                       req_valid,
  input  logic [AMT_W-1:0]           req_amount,
  output logic                       req_ready,
  output logic                       coin_valid,
  output logic [IDX_W-1:0]           coin_idx,
  input  logic                       coin_ready,
  output logic                       done_valid,
  output logic                       done_short,
  output logic [AMT_W-1:0]           done_remain,
  output logic [NUM_DENOM*CNT_W-1:0] counts,
  output logic [NUM_DENOM-1:0]       empty,
  output logic                       all_empty
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt   [NUM_DENOM];
  logic [AMT_W-1:0]   denom [NUM_DENOM];
  logic [AMT_W-1:0]   remain;
  logic [NUM_DENOM-1:0] eligible;
  logic               any_eligible;
  logic [IDX_W-1:0]   sel;
  logic [AMT_W-1:0]   remain_after;
  logic               req_fire;
  logic               coin_fire;
  logic               finish;
  logic               finish_short;
  logic [AMT_W-1:0]   finish_remain;

  for (genvar g = 0; g < NUM_DENOM; g++) begin : g_denom
    assign denom[g]    = AMT_W'(denom_field(VEC_MAX'(DENOM_VALUES), g, AMT_W));
    assign eligible[g] = (cnt[g] != '0) && (denom[g] <= remain);
    assign counts[g*CNT_W +: CNT_W] = cnt[g];
    assign empty[g]    = (cnt[g] == '0);
  end

  assign all_empty = &empty;

  coin_select_prio #(
    .NUM_DENOM (NUM_DENOM),
    .IDX_W     (IDX_W)
  ) u_select (
    .eligible     (eligible),
    .any_eligible (any_eligible),
    .sel          (sel)
  );

  // Everything on the coin interface derives from registers only.
  assign coin_valid   = (state == DISPENSE) && (remain != '0) && any_eligible;
  assign coin_idx     = sel;
  assign coin_fire    = coin_valid && coin_ready;
  assign remain_after = remain - denom[sel];

  assign req_ready  = (state == IDLE) && !load && !reset;
  assign req_fire   = req_valid && req_ready;
  assign done_valid = (state == DONE);

  always_comb begin
    state_nxt     = state;
    finish        = 1'b0;
    finish_short  = 1'b0;
    finish_remain = remain;
    case (state)
      IDLE: begin
        if (req_fire) state_nxt = DISPENSE;
      end
      DISPENSE: begin
        if (remain == '0) begin
          finish = 1'b1;
        end else if (!any_eligible) begin
          finish       = 1'b1;
          finish_short = 1'b1;
        end else if (coin_fire && (remain_after == '0)) begin
          // Exact payment completes on the last coin's handshake edge.
          finish        = 1'b1;
          finish_remain = '0;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (finish) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remain      <= '0;
      done_short  <= 1'b0;
      done_remain <= '0;
      for (int i = 0; i < NUM_DENOM; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && load) begin
        for (int i = 0; i < NUM_DENOM; i++) cnt[i] <= load_counts[i*CNT_W +: CNT_W];
      end else if (coin_fire) begin
        cnt[sel] <= cnt[sel] - CNT_W'(1);
      end
      if (req_fire) remain <= req_amount;
      else if (coin_fire) remain <= remain_after;
      if (finish) begin
        done_short  <= finish_short;
        done_remain <= finish_remain;
      end
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
module tb_coin_change_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] load_counts;
  logic        req_valid;
  logic [11:0] req_amount;
  logic        req_ready;
  logic        coin_valid;
  logic [1:0]  coin_idx;
  logic        coin_ready;
  logic        done_valid;
  logic        done_short;
  logic [11:0] done_remain;
  logic [31:0] counts;
  logic [3:0]  empty;
  logic        all_empty;

  coin_change_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_counts (load_counts),
    .req_valid   (req_valid),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .coin_valid  (coin_valid),
    .coin_idx    (coin_idx),
    .coin_ready  (coin_ready),
    .done_valid  (done_valid),
    .done_short  (done_short),
    .done_remain (done_remain),
    .counts      (counts),
    .empty       (empty),
    .all_empty   (all_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  int val [4] = '{25, 10, 5, 1};
  int m_cnt [4];
  int exp_q [$];
  int got   [$];
  bit exp_done = 0;
  bit exp_short;
  int exp_remain;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc  = 0;
  bit prev_stall = 0;
  logic [1:0] prev_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Greedy change from the model's store: largest coins first, as many as fit.
  task automatic model_req(input int amt);
    int rem;
    rem = amt;
    exp_q.delete();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      while (m_cnt[i] > 0 && val[i] <= rem) begin
        exp_q.push_back(i);
        m_cnt[i]--;
        rem -= val[i];
      end
    end
    exp_short  = (rem != 0);
    exp_remain = rem;
    exp_done   = 1;
  endtask

  function automatic logic [31:0] pack(input int c0, input int c1, input int c2, input int c3);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  // Compare process: coin handshakes and done pulses against the model.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", coin_valid, 1);
        check("stall_hold_idx", coin_idx, prev_idx);
      end
      if (coin_valid && coin_ready) begin
        got.push_back(int'(coin_idx));
        check("coin_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("coin_idx", coin_idx, exp_q.pop_front());
      end
      if (done_valid) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_expected", exp_done, 1);
        if (exp_done) begin
          check("done_short", done_short, exp_short);
          check("done_remain", done_remain, exp_remain);
          check("done_all_coins", exp_q.size(), 0);
        end
        exp_done = 0;
      end
      prev_stall = coin_valid && !coin_ready;
      prev_idx   = coin_idx;
    end
  end

  // Caller is aligned at posedge+1.
  task automatic do_load(input int c0, input int c1, input int c2, input int c3);
    load = 1; load_counts = pack(c0, c1, c2, c3);
    @(posedge clk); #1;
    load = 0;
    m_cnt = '{c0, c1, c2, c3};
  endtask

  task automatic do_req(input int amt);
    bit ok;
    ok = 0;
    model_req(amt);
    req_valid = 1; req_amount = amt[11:0];
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    check("req_accept_timeout", ok, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 0;
  endtask

  task automatic wait_done();
    int start;
    bit ok;
    start = done_cnt; ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (done_cnt > start) begin ok = 1; break; end
    end
    check("done_timeout", ok, 1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; load = 0; load_counts = '0; req_valid = 0; req_amount = '0; coin_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_coin_valid", coin_valid, 0);
    check("reset_done_valid", done_valid, 0);
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("post_reset_req_ready", req_ready, 1);
    check("post_reset_counts", counts, 0);
    check("post_reset_empty", empty, 4'hF);
    check("post_reset_all_empty", all_empty, 1);
    check("post_reset_done_short", done_short, 0);
    check("post_reset_done_remain", done_remain, 0);
    @(posedge clk); #1;

    // Full greedy payout of 68
    do_load(2, 3, 4, 5);
    check("load_counts_68", counts, 32'h05040302);
    do_req(68);
    wait_done();
    check("seq68_len", got.size(), 7);
    begin
      int ref68 [7] = '{0, 0, 1, 2, 3, 3, 3};
      for (int i = 0; i < 7 && i < got.size(); i++) check("seq68_idx", got[i], ref68[i]);
    end
    check("done_latency_68", done_cyc - acc_cyc, 7);
    check("counts_after_68", counts, 32'h02030200);
    check("counts_model_68", counts, pack(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]));

    // Shortfall: only one nickel for 7 cents
    do_load(0, 0, 1, 0);
    do_req(7);
    wait_done();
    check("short_seq_len", got.size(), 1);
    check("short_all_empty", all_empty, 1);
    check("short_empty", empty, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check("short_hold_flag", done_short, 1);
    check("short_hold_remain", done_remain, 2);

    // Backpressure on the first coin of 30
    do_load(2, 3, 4, 5);
    coin_ready = 0;
    do_req(30);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", coin_valid, 1);
      check("stall_idx", coin_idx, 0);
      check("stall_counts", counts, 32'h05040302);
    end
    @(posedge clk); #1; coin_ready = 1;
    wait_done();
    check("seq30_len", got.size(), 2);
    if (got.size() == 2) begin
      check("seq30_first", got[0], 0);
      check("seq30_second", got[1], 2);
    end
    check("counts_after_30", counts, 32'h05030301);

    // load during DISPENSE is ignored
    do_load(2, 3, 4, 5);
    do_req(68);
    load = 1; load_counts = 32'hFFFF_FFFF;
    wait_done();
    load = 0;
    check("load_ignored_counts", counts, 32'h02030200);
    @(posedge clk); #1;

    // load together with a request in IDLE: load wins, request next cycle
    load = 1; load_counts = pack(1, 1, 1, 1);
    req_valid = 1; req_amount = 12'd5;
    @(negedge clk);
    check("load_blocks_req_ready", req_ready, 0);
    @(posedge clk); #1;
    load = 0;
    m_cnt = '{1, 1, 1, 1};
    model_req(5);
    @(negedge clk);
    check("load_then_req_ready", req_ready, 1);
    check("load_then_counts", counts, 32'h01010101);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 0;
    wait_done();
    check("load_req_counts", counts, 32'h01000101);

    // Reset after the second coin of 68
    do_load(2, 3, 4, 5);
    do_req(68);
    begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(posedge clk);
        if (got.size() >= 2) begin ok = 1; break; end
      end
      check("two_coins_timeout", ok, 1);
    end
    #1; reset = 1;
    exp_q.delete(); exp_done = 0;
    m_cnt = '{0, 0, 0, 0};
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("abort_counts", counts, 0);
    check("abort_coin_valid", coin_valid, 0);
    check("abort_done_valid", done_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_all_empty", all_empty, 1);
    repeat (4) @(posedge clk);
    #1;

    // Zero amount
    do_load(2, 3, 4, 5);
    do_req(0);
    wait_done();
    check("zero_no_coins", got.size(), 0);
    check("zero_latency", done_cyc - acc_cyc, 1);
    check("zero_counts", counts, 32'h05040302);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
